// File: rtl/frame_diff_stats_if.sv
// rtl/frame_diff_stats_if.sv - pixel-pair stream and statistics result bundle
// Purpose: carries the DVI/CCD pixel pair with its sync coordinates into
//   frame_diff_stats, and the per-frame statistics back out.
// Ports (per modport):
//   master : drives pix_valid_i, syncX_i, syncY_i, DVI_{R,G,B}_i, CCD_{R,G,B}_i;
//            observes AMB_SHIFT_{R,G,B}_o, thershold_o, stats_valid_o, busy_o, overrun_o
//   slave  : the reverse direction of every signal above
interface frame_diff_stats_if #(
  parameter int XY_W = 10,
  parameter int RB_W = 5,
  parameter int G_W  = 6
);
  logic            pix_valid_i;
  logic [XY_W-1:0] syncX_i;
  logic [XY_W-1:0] syncY_i;
  logic [RB_W-1:0] DVI_R_i;
  logic [G_W-1:0]  DVI_G_i;
  logic [RB_W-1:0] DVI_B_i;
  logic [RB_W-1:0] CCD_R_i;
  logic [G_W-1:0]  CCD_G_i;
  logic [RB_W-1:0] CCD_B_i;

  logic [7:0]      AMB_SHIFT_R_o;
  logic [7:0]      AMB_SHIFT_G_o;
  logic [7:0]      AMB_SHIFT_B_o;
  logic [31:0]     thershold_o;
  logic            stats_valid_o;
  logic            busy_o;
  logic            overrun_o;

  modport master (
    output pix_valid_i, syncX_i, syncY_i,
    output DVI_R_i, DVI_G_i, DVI_B_i, CCD_R_i, CCD_G_i, CCD_B_i,
    input  AMB_SHIFT_R_o, AMB_SHIFT_G_o, AMB_SHIFT_B_o, thershold_o,
    input  stats_valid_o, busy_o, overrun_o
  );

  modport slave (
    input  pix_valid_i, syncX_i, syncY_i,
    input  DVI_R_i, DVI_G_i, DVI_B_i, CCD_R_i, CCD_G_i, CCD_B_i,
    output AMB_SHIFT_R_o, AMB_SHIFT_G_o, AMB_SHIFT_B_o, thershold_o,
    output stats_valid_o, busy_o, overrun_o
  );
endinterface

// File: rtl/frame_diff_stats.sv
// rtl/frame_diff_stats.sv - per-frame DVI vs CCD difference statistics engine
// Purpose: accumulates per-channel absolute differences and squared feature
//   distance over each active frame, snapshots the sums at the last active
//   pixel and divides them by the frame size on one shared restoring divider
//   while the next frame keeps accumulating.
// Ports:
//   clk_25 : sole clock
//   reset  : synchronous active-high reset
//   bus    : frame_diff_stats_if slave - pixel stream in, statistics out
//            (AMB_SHIFT_{R,G,B}_o, thershold_o, stats_valid_o, busy_o, overrun_o)
module frame_diff_stats #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          XY_W       = 10,
  parameter int          RB_W       = 5,
  parameter int          G_W        = 6,
  parameter int          ACC_W      = 32,
  parameter logic [31:0] THR_OFFSET = 32'd0
) (
  input  logic               clk_25,
  input  logic               reset,
  frame_diff_stats_if.slave  bus
);
  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int FD_W      = 2 * G_W + 2;
  localparam int CNT_W     = $clog2(ACC_W);
  localparam int TW        = ((ACC_W > 32) ? ACC_W : 32) + 1;
  localparam logic [ACC_W-1:0] DIVISOR  = ACC_W'(FRAME_PIX);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(ACC_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV    = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Pixel front end
  // ---------------------------------------------------------------------
  logic            pix_accept;
  logic            pix_last;
  logic [RB_W-1:0] abs_r;
  logic [RB_W-1:0] abs_b;
  logic [G_W-1:0]  abs_g;
  logic [G_W-1:0]  d_r;
  logic [G_W-1:0]  d_g;
  logic [G_W-1:0]  d_b;
  logic [FD_W-1:0] fd2;
  logic [ACC_W-1:0] addend [4];

  always_comb begin
    pix_accept = bus.pix_valid_i
              && (32'(bus.syncX_i) < 32'(H_ACTIVE))
              && (32'(bus.syncY_i) < 32'(V_ACTIVE));
    pix_last   = pix_accept
              && (32'(bus.syncX_i) == 32'(H_ACTIVE - 1))
              && (32'(bus.syncY_i) == 32'(V_ACTIVE - 1));

    abs_r = (bus.DVI_R_i >= bus.CCD_R_i) ? (bus.DVI_R_i - bus.CCD_R_i)
                                         : (bus.CCD_R_i - bus.DVI_R_i);
    abs_g = (bus.DVI_G_i >= bus.CCD_G_i) ? (bus.DVI_G_i - bus.CCD_G_i)
                                         : (bus.CCD_G_i - bus.DVI_G_i);
    abs_b = (bus.DVI_B_i >= bus.CCD_B_i) ? (bus.DVI_B_i - bus.CCD_B_i)
                                         : (bus.CCD_B_i - bus.DVI_B_i);

    // R/B are brought onto the G scale so all three channels share one width.
    d_r = G_W'(abs_r) << (G_W - RB_W);
    d_g = abs_g;
    d_b = G_W'(abs_b) << (G_W - RB_W);

    fd2 = FD_W'(d_r) * FD_W'(d_r)
        + FD_W'(d_g) * FD_W'(d_g)
        + FD_W'(d_b) * FD_W'(d_b);

    addend[0] = ACC_W'(d_r);
    addend[1] = ACC_W'(d_g);
    addend[2] = ACC_W'(d_b);
    addend[3] = ACC_W'(fd2);
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [ACC_W-1:0] sum_q  [4];
  logic [ACC_W-1:0] sum_d  [4];
  logic [ACC_W-1:0] snap_q [4];
  logic [ACC_W-1:0] snap_d [4];
  logic [ACC_W-1:0] quot_q [4];
  logic [ACC_W-1:0] quot_d [4];
  logic [ACC_W-1:0] rem_q, rem_d;
  logic [ACC_W-1:0] dvd_q, dvd_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       amb_r_q, amb_r_d;
  logic [7:0]       amb_g_q, amb_g_d;
  logic [7:0]       amb_b_q, amb_b_d;
  logic [31:0]      thr_q, thr_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             take_snap;
  logic [ACC_W:0]   trial;
  logic             q_bit;
  logic [ACC_W-1:0] rem_next;
  logic [ACC_W-1:0] dvd_next;
  logic [TW-1:0]    thr_sum;

  function automatic logic [7:0] sat_amb(input logic [ACC_W-1:0] q);
    if (q > ACC_W'(63)) begin
      return 8'hFF;
    end
    return {q[5:0], 2'b00};
  endfunction

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    snap_d    = snap_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    bit_d     = bit_q;
    sel_d     = sel_q;
    amb_r_d   = amb_r_q;
    amb_g_d   = amb_g_q;
    amb_b_d   = amb_b_q;
    thr_d     = thr_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;
    take_snap = 1'b0;

    // Restoring division step: the dividend shifts out MSB-first into the
    // partial remainder while quotient bits shift into its LSB end.
    trial    = {rem_q, dvd_q[ACC_W-1]};
    q_bit    = (trial >= {1'b0, DIVISOR});
    rem_next = q_bit ? ACC_W'(trial - {1'b0, DIVISOR}) : trial[ACC_W-1:0];
    dvd_next = {dvd_q[ACC_W-2:0], q_bit};

    thr_sum  = TW'(quot_q[3]) + TW'(THR_OFFSET);

    // Accumulation never stalls; the frame end clears the sums whether or
    // not the divider is free to take them.
    if (pix_accept) begin
      for (int i = 0; i < 4; i++) begin
        sum_d[i] = pix_last ? '0 : (sum_q[i] + addend[i]);
      end
      if (pix_last) begin
        if (state_q == ST_IDLE) begin
          take_snap = 1'b1;
          for (int i = 0; i < 4; i++) begin
            snap_d[i] = sum_q[i] + addend[i];
          end
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (take_snap) begin
          state_d = ST_DIV;
          dvd_d   = sum_q[0] + addend[0];
          rem_d   = '0;
          bit_d   = '0;
          sel_d   = '0;
        end
      end
      ST_DIV: begin
        rem_d = rem_next;
        dvd_d = dvd_next;
        bit_d = bit_q + CNT_W'(1);
        if (bit_q == LAST_BIT) begin
          quot_d[sel_q] = dvd_next;
          bit_d         = '0;
          rem_d         = '0;
          if (sel_q == 2'd3) begin
            state_d = ST_UPDATE;
          end else begin
            sel_d = sel_q + 2'd1;
            dvd_d = snap_q[sel_q + 2'd1];
          end
        end
      end
      ST_UPDATE: begin
        amb_r_d = sat_amb(quot_q[0]);
        amb_g_d = sat_amb(quot_q[1]);
        amb_b_d = sat_amb(quot_q[2]);
        thr_d   = (thr_sum > TW'(33'h0_FFFF_FFFF)) ? 32'hFFFF_FFFF : thr_sum[31:0];
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sum_q     <= '{default: '0};
      snap_q    <= '{default: '0};
      quot_q    <= '{default: '0};
      rem_q     <= '0;
      dvd_q     <= '0;
      bit_q     <= '0;
      sel_q     <= '0;
      amb_r_q   <= '0;
      amb_g_q   <= '0;
      amb_b_q   <= '0;
      thr_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      snap_q    <= snap_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      bit_q     <= bit_d;
      sel_q     <= sel_d;
      amb_r_q   <= amb_r_d;
      amb_g_q   <= amb_g_d;
      amb_b_q   <= amb_b_d;
      thr_q     <= thr_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.AMB_SHIFT_R_o = amb_r_q;
  assign bus.AMB_SHIFT_G_o = amb_g_q;
  assign bus.AMB_SHIFT_B_o = amb_b_q;
  assign bus.thershold_o   = thr_q;
  assign bus.stats_valid_o = valid_q;
  assign bus.busy_o        = busy_q;
  assign bus.overrun_o     = overrun_q;
endmodule

// File: tb/tb_frame_diff_stats.sv
// tb/tb_frame_diff_stats.sv - randomized, model-checked bench for frame_diff_stats
module tb_frame_diff_stats;
  localparam int          H     = 4;
  localparam int          V     = 2;
  localparam int          XY_W  = 10;
  localparam int          RB_W  = 5;
  localparam int          G_W   = 6;
  localparam int          ACC_W = 32;
  localparam logic [31:0] THR_B = 32'hFFFF_FFFE;
  localparam int          LAT   = 4 * ACC_W + 1;

  logic clk_25 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_25 = ~clk_25;

  frame_diff_stats_if #(.XY_W(XY_W), .RB_W(RB_W), .G_W(G_W)) if_a ();
  frame_diff_stats_if #(.XY_W(XY_W), .RB_W(RB_W), .G_W(G_W)) if_b ();

  assign if_b.pix_valid_i = if_a.pix_valid_i;
  assign if_b.syncX_i     = if_a.syncX_i;
  assign if_b.syncY_i     = if_a.syncY_i;
  assign if_b.DVI_R_i     = if_a.DVI_R_i;
  assign if_b.DVI_G_i     = if_a.DVI_G_i;
  assign if_b.DVI_B_i     = if_a.DVI_B_i;
  assign if_b.CCD_R_i     = if_a.CCD_R_i;
  assign if_b.CCD_G_i     = if_a.CCD_G_i;
  assign if_b.CCD_B_i     = if_a.CCD_B_i;

  frame_diff_stats #(
    .H_ACTIVE(H), .V_ACTIVE(V), .XY_W(XY_W), .RB_W(RB_W), .G_W(G_W),
    .ACC_W(ACC_W), .THR_OFFSET(32'd0)
  ) dut_a (.clk_25(clk_25), .reset(reset), .bus(if_a));

  frame_diff_stats #(
    .H_ACTIVE(H), .V_ACTIVE(V), .XY_W(XY_W), .RB_W(RB_W), .G_W(G_W),
    .ACC_W(ACC_W), .THR_OFFSET(THR_B)
  ) dut_b (.clk_25(clk_25), .reset(reset), .bus(if_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: frame sums with plain integers, quotient by '/'
  // ---------------------------------------------------------------------
  longint acc [4];
  longint pq  [4];
  bit     pend = 1'b0;
  longint upd_edge = 0;
  longint cyc = 0;
  bit     started = 1'b0;
  longint e_r = 0, e_g = 0, e_b = 0, e_thr_a = 0, e_thr_b = 0;
  bit     e_valid = 1'b0, e_busy = 1'b0, e_ovr = 1'b0;

  function automatic int absd(input int a, input int b);
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic longint amb_of(input longint q);
    return (q * 4 > 255) ? 255 : q * 4;
  endfunction

  function automatic longint thr_of(input longint q, input longint off);
    return (q + off > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : q + off;
  endfunction

  always @(posedge clk_25) begin
    bit was_busy;
    int dr, dg, db;
    cyc++;
    started = 1'b1;
    e_valid = 1'b0;
    e_ovr   = 1'b0;
    if (reset) begin
      for (int i = 0; i < 4; i++) acc[i] = 0;
      pend = 1'b0;
      e_r = 0; e_g = 0; e_b = 0; e_thr_a = 0; e_thr_b = 0;
      e_busy = 1'b0;
    end else begin
      was_busy = pend;
      if (pend && cyc == upd_edge) begin
        e_r     = amb_of(pq[0]);
        e_g     = amb_of(pq[1]);
        e_b     = amb_of(pq[2]);
        e_thr_a = thr_of(pq[3], 0);
        e_thr_b = thr_of(pq[3], longint'(THR_B));
        pend    = 1'b0;
        e_valid = 1'b1;
      end
      if (if_a.pix_valid_i && int'(if_a.syncX_i) < H && int'(if_a.syncY_i) < V) begin
        dr = absd(int'(if_a.DVI_R_i), int'(if_a.CCD_R_i)) * (1 << (G_W - RB_W));
        dg = absd(int'(if_a.DVI_G_i), int'(if_a.CCD_G_i));
        db = absd(int'(if_a.DVI_B_i), int'(if_a.CCD_B_i)) * (1 << (G_W - RB_W));
        acc[0] += dr;
        acc[1] += dg;
        acc[2] += db;
        acc[3] += dr * dr + dg * dg + db * db;
        if (int'(if_a.syncX_i) == H - 1 && int'(if_a.syncY_i) == V - 1) begin
          if (was_busy) begin
            e_ovr = 1'b1;
          end else begin
            for (int i = 0; i < 4; i++) pq[i] = acc[i] / (H * V);
            pend     = 1'b1;
            upd_edge = cyc + LAT;
          end
          for (int i = 0; i < 4; i++) acc[i] = 0;
        end
      end
      e_busy = pend;
    end
  end

  always @(negedge clk_25) begin
    if (started) begin
      chk("valid_a", if_a.stats_valid_o, e_valid);
      chk("busy_a",  if_a.busy_o,        e_busy);
      chk("ovr_a",   if_a.overrun_o,     e_ovr);
      chk("amb_r_a", if_a.AMB_SHIFT_R_o, e_r);
      chk("amb_g_a", if_a.AMB_SHIFT_G_o, e_g);
      chk("amb_b_a", if_a.AMB_SHIFT_B_o, e_b);
      chk("thr_a",   if_a.thershold_o,   e_thr_a);
      chk("valid_b", if_b.stats_valid_o, e_valid);
      chk("busy_b",  if_b.busy_o,        e_busy);
      chk("ovr_b",   if_b.overrun_o,     e_ovr);
      chk("amb_r_b", if_b.AMB_SHIFT_R_o, e_r);
      chk("thr_b",   if_b.thershold_o,   e_thr_b);
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic pix(input bit v, input int x, input int y,
                     input int dr, input int dg, input int db,
                     input int cr, input int cg, input int cb);
    @(negedge clk_25);
    if_a.pix_valid_i = v;
    if_a.syncX_i = XY_W'(x);
    if_a.syncY_i = XY_W'(y);
    if_a.DVI_R_i = RB_W'(dr);
    if_a.DVI_G_i = G_W'(dg);
    if_a.DVI_B_i = RB_W'(db);
    if_a.CCD_R_i = RB_W'(cr);
    if_a.CCD_G_i = G_W'(cg);
    if_a.CCD_B_i = RB_W'(cb);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_25);
      if_a.pix_valid_i = 1'b0;
    end
  endtask

  task automatic junk();
    case ($urandom_range(0, 2))
      0: pix(1'b0, $urandom_range(0, H - 1), $urandom_range(0, V - 1), 31, 63, 31, 0, 0, 0);
      1: pix(1'b1, H + $urandom_range(0, 50), $urandom_range(0, V - 1), 31, 63, 31, 0, 0, 0);
      default: pix(1'b1, $urandom_range(0, H - 1), V + $urandom_range(0, 50), 0, 0, 0, 31, 63, 31);
    endcase
  endtask

  task automatic uniform_frame(input int dr, input int dg, input int db,
                               input int cr, input int cg, input int cb);
    for (int p = 0; p < H * V; p++) pix(1'b1, p % H, p / H, dr, dg, db, cr, cg, cb);
  endtask

  task automatic rand_frame(input bit with_junk);
    for (int p = 0; p < H * V; p++) begin
      if (with_junk) repeat ($urandom_range(0, 2)) junk();
      pix(1'b1, p % H, p / H,
          $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 31));
    end
  endtask

  // Called right after the last pixel was driven: the next rising edge is
  // the snapshot edge, from which the stats pulse latency is counted.
  task automatic wait_stats(output int lat);
    lat = -1;
    @(posedge clk_25);
    #1;
    if_a.pix_valid_i = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk_25);
      #1;
      if (if_a.stats_valid_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    @(negedge clk_25);
    if_a.pix_valid_i = 1'b0;
    for (int k = 0; k < 400 && if_a.busy_o; k++) @(negedge clk_25);
    @(negedge clk_25);
    chk("idle_busy", if_a.busy_o, 0);
  endtask

  task automatic chk_uniform(input string tag);
    chk({tag, "_amb_r"}, if_a.AMB_SHIFT_R_o, 48);
    chk({tag, "_amb_g"}, if_a.AMB_SHIFT_G_o, 40);
    chk({tag, "_amb_b"}, if_a.AMB_SHIFT_B_o, 0);
    chk({tag, "_thr"},   if_a.thershold_o,   244);
    chk({tag, "_thr_b"}, if_b.thershold_o,   64'hFFFF_FFFF);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;
    if_a.pix_valid_i = 1'b0;
    if_a.syncX_i = '0; if_a.syncY_i = '0;
    if_a.DVI_R_i = '0; if_a.DVI_G_i = '0; if_a.DVI_B_i = '0;
    if_a.CCD_R_i = '0; if_a.CCD_G_i = '0; if_a.CCD_B_i = '0;

    // Reset state
    repeat (3) @(posedge clk_25);
    @(negedge clk_25);
    chk("rst_amb_r", if_a.AMB_SHIFT_R_o, 0);
    chk("rst_thr",   if_a.thershold_o,   0);
    chk("rst_busy",  if_a.busy_o,        0);
    chk("rst_valid", if_a.stats_valid_o, 0);
    reset = 1'b0;

    // Uniform frame: dR=6<<1=12, dG=10, dB=0, FD2=244
    idle(2);
    uniform_frame(10, 40, 7, 4, 50, 7);
    wait_stats(lat);
    chk("uni_lat", lat, 129);
    chk_uniform("uni");

    // Floor rounding: G sum 87 -> 10, FD2 sum 2141 -> 267
    idle(3);
    for (int p = 0; p < H * V; p++) pix(1'b1, p % H, p / H, 10, 40, 7, 4, (p == 3) ? 57 : 50, 7);
    wait_stats(lat);
    chk("flr_amb_g", if_a.AMB_SHIFT_G_o, 40);
    chk("flr_thr",   if_a.thershold_o,   267);

    // Saturation: dR=31 scaled to 62 -> 248; FD2 3844
    idle(3);
    uniform_frame(31, 20, 3, 0, 20, 3);
    wait_stats(lat);
    chk("sat_amb_r", if_a.AMB_SHIFT_R_o, 248);
    chk("sat_amb_g", if_a.AMB_SHIFT_G_o, 0);
    chk("sat_thr",   if_a.thershold_o,   3844);
    chk("sat_thr_b", if_b.thershold_o,   64'hFFFF_FFFF);

    // Masking: ignored pixels with large differences, including invalid
    // and out-of-range pixels at the last-pixel coordinates
    idle(3);
    for (int p = 0; p < H * V; p++) begin
      repeat ($urandom_range(0, 2)) junk();
      if (p == H * V - 1) begin
        pix(1'b0, H - 1, V - 1, 31, 63, 31, 0, 0, 0);
        pix(1'b1, H, V - 1, 31, 63, 31, 0, 0, 0);
      end
      pix(1'b1, p % H, p / H, 10, 40, 7, 4, 50, 7);
    end
    wait_stats(lat);
    chk("msk_lat", lat, 129);
    chk_uniform("msk");

    // Overrun: back-to-back frames, second frame end is dropped
    idle(3);
    uniform_frame(10, 40, 7, 4, 50, 7);
    rand_frame(1'b0);
    @(posedge clk_25);
    #1;
    if_a.pix_valid_i = 1'b0;
    chk("ovr_pulse", if_a.overrun_o, 1);
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk_25);
      #1;
      if (if_a.stats_valid_o) cnt++;
    end
    chk("ovr_stats_cnt", cnt, 1);
    chk("ovr_busy", if_a.busy_o, 0);
    chk_uniform("ovr");
    rand_frame(1'b1);
    wait_stats(lat);
    chk("f3_lat", lat, 129);

    // Reset 50 cycles after the snapshot aborts the division
    idle(3);
    rand_frame(1'b1);
    @(posedge clk_25);
    #1;
    if_a.pix_valid_i = 1'b0;
    repeat (49) @(posedge clk_25);
    @(negedge clk_25);
    reset = 1'b1;
    @(negedge clk_25);
    chk("mrst_amb_r", if_a.AMB_SHIFT_R_o, 0);
    chk("mrst_amb_g", if_a.AMB_SHIFT_G_o, 0);
    chk("mrst_thr",   if_a.thershold_o,   0);
    chk("mrst_busy",  if_a.busy_o,        0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_25);
      if (if_a.stats_valid_o) cnt++;
    end
    chk("mrst_no_stats", cnt, 0);
    rand_frame(1'b1);
    wait_stats(lat);
    chk("mrst_next_lat", lat, 129);

    // Random frames, sometimes back-to-back to provoke overruns
    for (int f = 0; f < 10; f++) begin
      rand_frame(1'b1);
      if ($urandom_range(0, 2) != 0) wait_idle();
    end
    wait_idle();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
